multicycle_control_unit: RTL

Multi-cycle successor to the single-cycle opcode decoder in the RISC core. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on ready handshakes from instruction and data memory. It issues per-state datapath strobes and keeps a retired-instruction counter. It sits between the instruction register and the shared datapath in place of the combinational decoder.

---
 rtl/multicycle_control_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle instruction sequencer for the RISC core. It replaces the
//   single-cycle opcode decoder and steps each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB), waiting on memory ready
//   handshakes. It issues the datapath strobes for each state and counts
//   retired instructions.
//
// Build option:
//   ILLEGAL_TRAP_EN  defined   : an illegal opcode enters TRAP (sticky
//                                illegal_op, left only by reset, not counted)
//                    undefined : an illegal opcode retires as a NOP from
//                                DECODE; illegal_op is tied to 0
//
// Parameters:
//   OPCODE_W  opcode width (>= 4); any bit above bit 3 set is illegal
//   CNT_W     retired-instruction counter width (wraps)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 run level; 0 stops at the next instruction boundary
//   opcode                IR opcode field, sampled in DECODE only
//   imem_ready/dmem_ready memory handshakes
//   imem_req..alu_op      datapath strobes (see output decode below)
//   state                 current state, debug
//   illegal_op            sticky illegal-opcode flag
//   retired_cnt           retired-instruction count
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_cond,
  output logic                beq,
  output logic                bne,
  output logic                jump,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic [2:0]          state,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [3:0] OP_LW  = 4'd0;
  localparam logic [3:0] OP_SW  = 4'd1;
  localparam logic [3:0] OP_BEQ = 4'd11;
  localparam logic [3:0] OP_BNE = 4'd12;
  localparam logic [3:0] OP_J   = 4'd13;

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic                retire;

  // Legal: upper bits clear, low nibble not 10/14/15.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    logic [3:0] lo;
    lo = 4'(op);
    return ((op >> 4) == '0) && (lo != 4'd10) && (lo != 4'd14) && (lo != 4'd15);
  endfunction

  // Class of the latched opcode; only meaningful once op_q holds a legal op.
  logic [3:0] op_lo;
  logic       is_lw, is_sw, is_ls, is_r, is_br, is_j;
  assign op_lo = 4'(op_q);
  assign is_lw = (op_lo == OP_LW);
  assign is_sw = (op_lo == OP_SW);
  assign is_ls = is_lw | is_sw;
  assign is_r  = (op_lo >= 4'd2) && (op_lo <= 4'd9);
  assign is_br = (op_lo == OP_BEQ) || (op_lo == OP_BNE);
  assign is_j  = (op_lo == OP_J);

  // Next state; retire marks the cycle an instruction completes.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_legal(opcode)) state_d = S_EXEC;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        if (is_ls)     state_d = S_MEM;
        else if (is_r) state_d = S_WB;
        else           retire  = 1'b1;
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (is_lw) state_d = S_WB;
          else       retire  = 1'b1;
        end
      end
      S_WB:   retire  = 1'b1;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = start ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      retired_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) retired_cnt <= retired_cnt + 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Set on the DECODE->TRAP transition so it reads 1 for the whole TRAP stay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_op <= 1'b0;
    else if (state_q == S_DECODE && !is_legal(opcode)) illegal_op <= 1'b1;
  end
`else
  assign illegal_op = 1'b0;
`endif

  assign state = state_q;

  // Strobe decode from state and op_q. The single exception to pure Moore
  // decode is the FETCH ir_write/pc_write pulse: it must fire exactly once,
  // on the cycle the fetched word is valid, so it is qualified by imem_ready.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_cond    = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    jump       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_EXEC: begin
        if (is_ls) begin
          alu_src = 1'b1;
          alu_op  = 2'b10;
        end else if (is_br) begin
          alu_op  = 2'b01;
          pc_cond = 1'b1;
          beq     = (op_lo == OP_BEQ);
          bne     = (op_lo == OP_BNE);
        end else if (is_j) begin
          jump     = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = ~is_lw;
        mem_to_reg = is_lw;
      end
      default: ;
    endcase
  end

endmodule
